// File: rtl/rv_mem_responder.sv
// Memory-side responder for the RV32 core: instruction/data BRAMs with
// one-cycle read latency, a small MMIO window, and a host program-load port.
module rv_mem_responder #(
   parameter int unsigned IMEM_WORDS = 1024,
   parameter int unsigned DMEM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] imem_addr,
   input  logic        imem_stall,
   output logic [31:0] imem_rdata,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_data,
   input  logic        host_last,
   output logic        core_rst_n,
   output logic [7:0]  led
);

   localparam int unsigned IA = $clog2(IMEM_WORDS);
   localparam int unsigned DA = $clog2(DMEM_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {LOAD, RUN} state_t;

   state_t      state_q, state_d;
   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] cycle_cnt;
   logic [31:0] mmio_rdata;
   logic        is_mmio;
   logic        beat_acc;
   logic [1:0]  mmio_off;
   logic [IA-1:0] fetch_idx, host_idx;
   logic [DA-1:0] data_idx;

   assign fetch_idx = imem_addr[IA+1:2];
   assign host_idx  = host_addr[IA+1:2];
   assign data_idx  = d_addr[DA+1:2];
   assign is_mmio   = (d_addr[31] == MMIO_BASE[31]);
   assign mmio_off  = d_addr[3:2];
   assign beat_acc  = host_valid && host_ready;

   // Address bits outside the decoded fields alias by design.
   logic unused_bits;
   assign unused_bits = ^{imem_addr[31:IA+2], imem_addr[1:0], host_addr[31:IA+2],
                          host_addr[1:0], d_addr[30:DA+2], d_addr[1:0], MMIO_BASE[30:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (beat_acc && host_last) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = LOAD;
      endcase
   end

   // Handshake and core reset are registered off the next state so they
   // flip on the same edge that accepts the final beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         host_ready <= 1'b0;
         core_rst_n <= 1'b0;
      end else begin
         host_ready <= (state_d == LOAD);
         core_rst_n <= (state_d == RUN);
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == LOAD && beat_acc) imem[host_idx] <= host_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)           imem_rdata <= NOP;
      else if (!imem_stall) imem_rdata <= imem[fetch_idx];
   end

   always_ff @(posedge clk) begin
      if (d_we && !is_mmio) dmem[data_idx] <= d_wdata;
   end

   always_comb begin
      mmio_rdata = 32'h0;
      case (mmio_off)
         2'd0:    mmio_rdata = {24'h0, led};
         2'd1:    mmio_rdata = cycle_cnt;
         2'd2:    mmio_rdata = {31'h0, state_q == RUN};
         default: mmio_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)       d_rdata <= 32'h0;
      else if (is_mmio) d_rdata <= mmio_rdata;
      else              d_rdata <= dmem[data_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                  led <= 8'h0;
      else if (is_mmio && d_we && mmio_off == 2'd0) led <= d_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)              cycle_cnt <= 32'h0;
      else if (state_q == RUN) cycle_cnt <= cycle_cnt + 32'd1;
   end

endmodule
